// File: rtl/router_fsm.sv
// Router input-stage packet sequencer; registered Moore strobes, header decode to LFD in one cycle.
// Backpressure: stalls in WTE/FFS on busy or full destination FIFO; busy asks the port to hold its byte.
module router_fsm #(
  parameter int NUM_PORTS = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 pkt_valid,
  input  logic [1:0]           data_in,
  input  logic                 fifo_full,
  input  logic [NUM_PORTS-1:0] fifo_empty,
  input  logic [NUM_PORTS-1:0] soft_reset,
  input  logic                 parity_done,
  input  logic                 low_pkt_valid,
  output logic                 detect_add,
  output logic                 lfd_state,
  output logic                 ld_state,
  output logic                 full_state,
  output logic                 laf_state,
  output logic                 rst_int_reg,
  output logic                 write_enb_reg,
  output logic [NUM_PORTS-1:0] write_enb,
  output logic                 busy
);

  typedef enum logic [2:0] {
    S_DA, S_LFD, S_LD, S_FFS, S_LAF, S_LP, S_CPE, S_WTE
  } state_t;

  localparam logic [2:0] NP = 3'(NUM_PORTS);

  state_t               state_q, state_d;
  logic   [1:0]         addr_q, addr_d;
  logic                 hdr_ok, hdr_empty, sel_empty, sel_soft, wer_d;
  logic [NUM_PORTS-1:0] we_d;

  always_comb begin
    hdr_ok    = ({1'b0, data_in} < NP);
    hdr_empty = 1'b0;
    sel_empty = 1'b0;
    sel_soft  = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (data_in == 2'(i)) hdr_empty = fifo_empty[i];
      if (addr_q == 2'(i)) begin
        sel_empty = fifo_empty[i];
        sel_soft  = soft_reset[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    if (state_q != S_DA && sel_soft) begin
      state_d = S_DA;
    end else begin
      case (state_q)
        S_DA: begin
          if (pkt_valid && hdr_ok) begin
            addr_d  = data_in;
            state_d = hdr_empty ? S_LFD : S_WTE;
          end
        end
        S_WTE:   if (sel_empty) state_d = S_LFD;
        S_LFD:   state_d = S_LD;
        S_LD: begin
          if (fifo_full)       state_d = S_FFS;
          else if (!pkt_valid) state_d = S_LP;
        end
        S_FFS:   if (!fifo_full) state_d = S_LAF;
        S_LAF: begin
          if (parity_done)        state_d = S_DA;
          else if (low_pkt_valid) state_d = S_LP;
          else                    state_d = S_LD;
        end
        S_LP:    state_d = S_CPE;
        S_CPE:   state_d = fifo_full ? S_FFS : S_DA;
        default: state_d = S_DA;
      endcase
    end
  end

  // Strobes are decoded from the next state so they leave the flops aligned with state_q.
  always_comb begin
    wer_d = (state_d == S_LD) || (state_d == S_LAF) || (state_d == S_LP);
    we_d  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      we_d[i] = wer_d && (addr_d == 2'(i));
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_DA;
      addr_q        <= 2'd0;
      detect_add    <= 1'b1;
      lfd_state     <= 1'b0;
      ld_state      <= 1'b0;
      full_state    <= 1'b0;
      laf_state     <= 1'b0;
      rst_int_reg   <= 1'b0;
      write_enb_reg <= 1'b0;
      write_enb     <= '0;
      busy          <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      detect_add    <= (state_d == S_DA);
      lfd_state     <= (state_d == S_LFD);
      ld_state      <= (state_d == S_LD);
      full_state    <= (state_d == S_FFS);
      laf_state     <= (state_d == S_LAF);
      rst_int_reg   <= (state_d == S_CPE);
      write_enb_reg <= wer_d;
      write_enb     <= we_d;
      busy          <= !((state_d == S_DA) || (state_d == S_LD));
    end
  end

endmodule
